// File: rtl/spi_adc_reader.sv
// Receive-side SPI master: frames the external ADC every 2*FRAME_LEN clocks, shifts MISO in MSB-first
// and hands each word downstream on a valid/ready handshake with sticky overrun detection.
module spi_adc_reader #(
    parameter int FRAME_LEN = 18,
    parameter int DATA_W    = 16,
    parameter int LEAD_BITS = 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    input  logic              adc_miso,
    output logic              adc_sclk,
    output logic              adc_cs_n,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun
);

    localparam int FRAME_PER = 2 * FRAME_LEN;
    localparam int K_W       = $clog2(FRAME_PER);
    localparam logic [K_W-1:0] K_LAST       = K_W'(FRAME_PER - 1);
    // The serial clock phase is packed against the end of the frame; the slack in front is the quiet period.
    localparam logic [K_W-1:0] K_FIRST_SCLK = K_W'(FRAME_PER - 2 * (LEAD_BITS + DATA_W) + 1);
    localparam logic [K_W-1:0] K_CS_LOW     = K_W'(FRAME_PER - 2 * (LEAD_BITS + DATA_W));

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [K_W-1:0]     r_k;
    logic [K_W-1:0]     w_kNext;
    logic               r_sclk;
    logic               r_csN;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_sample;
    logic               r_valid;
    logic               r_overrun;
    logic               w_frameEnd;
    logic               w_sclkNext;
    logic               w_csNNext;
    logic               w_shiftEn;

    always_comb begin
        w_stateNext = r_state;
        w_kNext     = '0;
        w_frameEnd  = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (r_k == K_LAST) begin
                    w_frameEnd = 1'b1;
                    if (!enable) begin
                        w_stateNext = IDLE;
                    end
                end else begin
                    w_kNext = r_k + 1'b1;
                end
            end
            default: w_stateNext = IDLE;
        endcase
        // Pins are registered from the next k so they line up with the k held in the counter.
        w_csNNext  = !((w_stateNext == RUN) && (w_kNext >= K_CS_LOW));
        w_sclkNext = (w_stateNext == RUN) && w_kNext[0] && (w_kNext >= K_FIRST_SCLK);
        w_shiftEn  = w_sclkNext && !r_sclk;
    end

    // Leading bits shift through the register and fall off the top before the frame closes.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_sclk    <= 1'b0;
            r_csN     <= 1'b1;
            r_shift   <= '0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_k     <= w_kNext;
            r_sclk  <= w_sclkNext;
            r_csN   <= w_csNNext;
            if (w_shiftEn) begin
                r_shift <= {r_shift[DATA_W-2:0], adc_miso};
            end
            if (w_frameEnd) begin
                if (!r_valid || sample_ready) begin
                    r_sample <= r_shift;
                    r_valid  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && sample_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign adc_sclk     = r_sclk;
    assign adc_cs_n     = r_csN;
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;

endmodule
